// File: rtl/bridge_xfer_buffer.sv
// bridge_xfer_buffer
// Transfer buffer between the AXI-side reader and the APB engine. Holds a
// queue of burst descriptors (address, length, ID) and a first-word-fall-
// through FIFO of data beats with byte strobes. The pop side walks the head
// descriptor beat by beat, producing the per-beat APB address and last flag,
// and retires the descriptor when its final beat is taken.
//
// Ports
//   clk_i, rst_i, flush_i                 clock, sync active-high reset, sync clear
//   info_push_*_i / info_push_ready_o     descriptor push handshake
//   data_push_*_i / data_push_ready_o     beat push handshake
//   info_valid_o, info_id_o, info_len_o   head descriptor view
//   data_pop_*_o / data_pop_ready_i       beat pop handshake with address and last
//   data_count_o, almost_full_o           data FIFO fill status
//   overflow_err_o, underflow_err_o       sticky error flags
module bridge_xfer_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int DEPTH      = 16,
    parameter int INFO_DEPTH = 4,
    parameter int AF_MARGIN  = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic                          info_push_valid_i,
    output logic                          info_push_ready_o,
    input  logic [ADDR_WIDTH-1:0]         info_push_addr_i,
    input  logic [7:0]                    info_push_len_i,
    input  logic [ID_WIDTH-1:0]           info_push_id_i,
    input  logic                          data_push_valid_i,
    output logic                          data_push_ready_o,
    input  logic [DATA_WIDTH-1:0]         data_push_data_i,
    input  logic [DATA_WIDTH/8-1:0]       data_push_strb_i,
    output logic                          info_valid_o,
    output logic [ID_WIDTH-1:0]           info_id_o,
    output logic [7:0]                    info_len_o,
    output logic                          data_pop_valid_o,
    input  logic                          data_pop_ready_i,
    output logic [DATA_WIDTH-1:0]         data_pop_data_o,
    output logic [DATA_WIDTH/8-1:0]       data_pop_strb_o,
    output logic [ADDR_WIDTH-1:0]         data_pop_addr_o,
    output logic                          data_pop_last_o,
    output logic [$clog2(DEPTH+1)-1:0]    data_count_o,
    output logic                          almost_full_o,
    output logic                          overflow_err_o,
    output logic                          underflow_err_o
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int DPW   = $clog2(DEPTH);
    localparam int DCW   = $clog2(DEPTH + 1);
    localparam int IPW   = $clog2(INFO_DEPTH);
    localparam int ICW   = $clog2(INFO_DEPTH + 1);
    // Owed beats are bounded by the lengths of queued descriptors: a
    // descriptor cannot retire before all its beats have been pushed.
    localparam int OW    = $clog2(INFO_DEPTH * 256 + 1);

    // Storage (not reset; visibility is governed by the counts)
    logic [ADDR_WIDTH-1:0]   info_addr_mem [INFO_DEPTH];
    logic [7:0]              info_len_mem  [INFO_DEPTH];
    logic [ID_WIDTH-1:0]     info_id_mem   [INFO_DEPTH];
    logic [DATA_WIDTH-1:0]   data_mem      [DEPTH];
    logic [BYTES-1:0]        strb_mem      [DEPTH];

    logic [IPW-1:0] info_wr_q, info_wr_d, info_rd_q, info_rd_d;
    logic [ICW-1:0] info_cnt_q, info_cnt_d;
    logic [DPW-1:0] data_wr_q, data_wr_d, data_rd_q, data_rd_d;
    logic [DCW-1:0] data_cnt_q, data_cnt_d;
    logic [7:0]     beat_idx_q, beat_idx_d;
    logic [OW-1:0]  owed_q, owed_d;
    logic           ovf_q, ovf_d, unf_q, unf_d;

    logic info_full, info_empty, data_full, data_empty;
    logic info_push, data_push, beat_pop, info_pop, last_beat, unf_evt;
    logic [ADDR_WIDTH-1:0] head_addr;

    assign info_full  = (info_cnt_q == ICW'(INFO_DEPTH));
    assign info_empty = (info_cnt_q == '0);
    assign data_full  = (data_cnt_q == DCW'(DEPTH));
    assign data_empty = (data_cnt_q == '0);

    assign info_push_ready_o = !info_full;
    assign data_push_ready_o = !data_full;
    assign info_push = info_push_valid_i && !info_full;
    assign data_push = data_push_valid_i && !data_full;

    assign info_valid_o     = !info_empty;
    assign data_pop_valid_o = !info_empty && !data_empty;
    assign last_beat        = !info_empty && (beat_idx_q == info_len_mem[info_rd_q]);
    assign beat_pop         = data_pop_valid_o && data_pop_ready_i;
    assign info_pop         = beat_pop && last_beat;

    // A beat that arrives together with its descriptor is not an underflow.
    assign unf_evt = data_push && (owed_q == '0) && !info_push;

    // Outputs are forced to zero when their queue is empty so stale storage
    // never leaks out after reset or flush.
    assign head_addr       = info_empty ? '0 : info_addr_mem[info_rd_q];
    assign info_id_o       = info_empty ? '0 : info_id_mem[info_rd_q];
    assign info_len_o      = info_empty ? '0 : info_len_mem[info_rd_q];
    assign data_pop_addr_o = info_empty ? '0
                           : head_addr + ADDR_WIDTH'(beat_idx_q) * ADDR_WIDTH'(BYTES);
    assign data_pop_last_o = last_beat;
    assign data_pop_data_o = data_empty ? '0 : data_mem[data_rd_q];
    assign data_pop_strb_o = data_empty ? '0 : strb_mem[data_rd_q];

    assign data_count_o    = data_cnt_q;
    assign almost_full_o   = (data_cnt_q >= DCW'(DEPTH - AF_MARGIN));
    assign overflow_err_o  = ovf_q;
    assign underflow_err_o = unf_q;

    always_comb begin
        info_wr_d  = info_wr_q;
        info_rd_d  = info_rd_q;
        info_cnt_d = info_cnt_q;
        data_wr_d  = data_wr_q;
        data_rd_d  = data_rd_q;
        data_cnt_d = data_cnt_q;
        beat_idx_d = beat_idx_q;
        owed_d     = owed_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;

        if (info_push) info_wr_d = info_wr_q + IPW'(1);
        if (info_pop)  info_rd_d = info_rd_q + IPW'(1);
        info_cnt_d = info_cnt_q + ICW'(info_push) - ICW'(info_pop);

        if (data_push) data_wr_d = data_wr_q + DPW'(1);
        if (beat_pop)  data_rd_d = data_rd_q + DPW'(1);
        data_cnt_d = data_cnt_q + DCW'(data_push) - DCW'(beat_pop);

        if (beat_pop) beat_idx_d = last_beat ? 8'd0 : beat_idx_q + 8'd1;

        if (info_push) owed_d = owed_d + OW'(info_push_len_i) + OW'(1);
        if (data_push && !unf_evt) owed_d = owed_d - OW'(1);

        if ((info_push_valid_i && info_full) || (data_push_valid_i && data_full))
            ovf_d = 1'b1;
        if (unf_evt) unf_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            info_wr_q  <= '0;
            info_rd_q  <= '0;
            info_cnt_q <= '0;
            data_wr_q  <= '0;
            data_rd_q  <= '0;
            data_cnt_q <= '0;
            beat_idx_q <= '0;
            owed_q     <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            info_wr_q  <= info_wr_d;
            info_rd_q  <= info_rd_d;
            info_cnt_q <= info_cnt_d;
            data_wr_q  <= data_wr_d;
            data_rd_q  <= data_rd_d;
            data_cnt_q <= data_cnt_d;
            beat_idx_q <= beat_idx_d;
            owed_q     <= owed_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i) begin
            if (info_push) begin
                info_addr_mem[info_wr_q] <= info_push_addr_i;
                info_len_mem[info_wr_q]  <= info_push_len_i;
                info_id_mem[info_wr_q]   <= info_push_id_i;
            end
            if (data_push) begin
                data_mem[data_wr_q] <= data_push_data_i;
                strb_mem[data_wr_q] <= data_push_strb_i;
            end
        end
    end

endmodule

// File: tb/tb_bridge_xfer_buffer.sv
// Directed self-checking bench for bridge_xfer_buffer (default parameters).
module tb_bridge_xfer_buffer;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        info_push_valid, info_push_ready;
    logic [31:0] info_push_addr;
    logic [7:0]  info_push_len;
    logic [3:0]  info_push_id;
    logic        data_push_valid, data_push_ready;
    logic [31:0] data_push_data;
    logic [3:0]  data_push_strb;
    logic        info_valid;
    logic [3:0]  info_id;
    logic [7:0]  info_len;
    logic        data_pop_valid, data_pop_ready;
    logic [31:0] data_pop_data;
    logic [3:0]  data_pop_strb;
    logic [31:0] data_pop_addr;
    logic        data_pop_last;
    logic [4:0]  data_count;
    logic        almost_full, overflow_err, underflow_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bridge_xfer_buffer dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .info_push_valid_i(info_push_valid), .info_push_ready_o(info_push_ready),
        .info_push_addr_i(info_push_addr), .info_push_len_i(info_push_len),
        .info_push_id_i(info_push_id),
        .data_push_valid_i(data_push_valid), .data_push_ready_o(data_push_ready),
        .data_push_data_i(data_push_data), .data_push_strb_i(data_push_strb),
        .info_valid_o(info_valid), .info_id_o(info_id), .info_len_o(info_len),
        .data_pop_valid_o(data_pop_valid), .data_pop_ready_i(data_pop_ready),
        .data_pop_data_o(data_pop_data), .data_pop_strb_o(data_pop_strb),
        .data_pop_addr_o(data_pop_addr), .data_pop_last_o(data_pop_last),
        .data_count_o(data_count), .almost_full_o(almost_full),
        .overflow_err_o(overflow_err), .underflow_err_o(underflow_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        info_push_valid = 1'b0; info_push_addr = '0; info_push_len = '0; info_push_id = '0;
        data_push_valid = 1'b0; data_push_data = '0; data_push_strb = '0;
        data_pop_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset values
        chk("rst_info_ready", 64'(info_push_ready), 64'(1));
        chk("rst_data_ready", 64'(data_push_ready), 64'(1));
        chk("rst_info_valid", 64'(info_valid), 64'(0));
        chk("rst_pop_valid",  64'(data_pop_valid), 64'(0));
        chk("rst_last",       64'(data_pop_last), 64'(0));
        chk("rst_count",      64'(data_count), 64'(0));
        chk("rst_af",         64'(almost_full), 64'(0));
        chk("rst_ovf",        64'(overflow_err), 64'(0));
        chk("rst_unf",        64'(underflow_err), 64'(0));
        chk("rst_data",       64'(data_pop_data), 64'(0));
        chk("rst_addr",       64'(data_pop_addr), 64'(0));

        // Single burst: 0x1000, 4 beats
        info_push_valid = 1'b1; info_push_addr = 32'h1000; info_push_len = 8'd3; info_push_id = 4'd5;
        tick();
        info_push_valid = 1'b0;
        chk("sb_info_valid", 64'(info_valid), 64'(1));
        chk("sb_info_len",   64'(info_len), 64'(3));
        chk("sb_info_id",    64'(info_id), 64'(5));
        for (int i = 0; i < 4; i++) begin
            data_push_valid = 1'b1; data_push_data = 32'hA0 + 32'(i); data_push_strb = 4'(i + 1);
            if (i == 0) chk("sb_no_bypass", 64'(data_pop_valid), 64'(0));
            tick();
            if (i == 0) chk("sb_latency", 64'(data_pop_valid), 64'(1));
        end
        data_push_valid = 1'b0;
        chk("sb_count", 64'(data_count), 64'(4));
        data_pop_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("sb_addr", 64'(data_pop_addr), 64'(32'h1000 + 32'(4 * i)));
            chk("sb_data", 64'(data_pop_data), 64'(32'hA0 + 32'(i)));
            chk("sb_strb", 64'(data_pop_strb), 64'(i + 1));
            chk("sb_last", 64'(data_pop_last), 64'(i == 3));
            tick();
        end
        data_pop_ready = 1'b0;
        chk("sb_retired",   64'(info_valid), 64'(0));
        chk("sb_empty",     64'(data_count), 64'(0));
        chk("sb_unf",       64'(underflow_err), 64'(0));

        // Fill: 16 beats, no pop
        info_push_valid = 1'b1; info_push_addr = 32'h2000; info_push_len = 8'd15; info_push_id = 4'd3;
        tick();
        info_push_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            data_push_valid = 1'b1; data_push_data = 32'h100 + 32'(i); data_push_strb = 4'hF;
            tick();
            chk("fill_count", 64'(data_count), 64'(i + 1));
            chk("fill_af",    64'(almost_full), 64'(i + 1 >= 14));
        end
        chk("fill_ready", 64'(data_push_ready), 64'(0));
        chk("fill_ovf0",  64'(overflow_err), 64'(0));
        data_push_data = 32'hDEAD;
        tick();
        data_push_valid = 1'b0;
        chk("fill_ovf1",  64'(overflow_err), 64'(1));
        chk("fill_cnt16", 64'(data_count), 64'(16));
        chk("fill_unf",   64'(underflow_err), 64'(0));

        // Full with simultaneous push attempt and pop
        data_push_valid = 1'b1; data_push_data = 32'hBEEF;
        data_pop_ready = 1'b1;
        chk("full_oldest", 64'(data_pop_data), 64'(32'h100));
        chk("full_addr",   64'(data_pop_addr), 64'(32'h2000));
        tick();
        data_push_valid = 1'b0;
        for (int i = 1; i < 16; i++) begin
            chk("drain_data", 64'(data_pop_data), 64'(32'h100 + 32'(i)));
            chk("drain_last", 64'(data_pop_last), 64'(i == 15));
            tick();
        end
        data_pop_ready = 1'b0;
        chk("drain_dropped", 64'(data_count), 64'(0));
        chk("drain_retired", 64'(info_valid), 64'(0));

        // Address wrap, descriptor and first beat in the same cycle
        info_push_valid = 1'b1; info_push_addr = 32'hFFFF_FFF8; info_push_len = 8'd3; info_push_id = 4'd7;
        for (int i = 0; i < 4; i++) begin
            data_push_valid = 1'b1; data_push_data = 32'hC0 + 32'(i); data_push_strb = 4'hF;
            tick();
            info_push_valid = 1'b0;
        end
        data_push_valid = 1'b0;
        chk("wrap_count", 64'(data_count), 64'(4));
        chk("wrap_unf",   64'(underflow_err), 64'(0));
        data_pop_ready = 1'b1;
        chk("wrap_a0", 64'(data_pop_addr), 64'(32'hFFFF_FFF8)); tick();
        chk("wrap_a1", 64'(data_pop_addr), 64'(32'hFFFF_FFFC)); tick();
        chk("wrap_a2", 64'(data_pop_addr), 64'(32'h0000_0000)); tick();
        chk("wrap_a3", 64'(data_pop_addr), 64'(32'h0000_0004));
        chk("wrap_last", 64'(data_pop_last), 64'(1));
        tick();
        chk("wrap_retired", 64'(info_valid), 64'(0));

        // Interleave: two descriptors, beats trickled one per 3 cycles
        info_push_valid = 1'b1; info_push_addr = 32'h3000; info_push_len = 8'd1; info_push_id = 4'd1;
        tick();
        info_push_addr = 32'h4000; info_push_len = 8'd0; info_push_id = 4'd2;
        tick();
        info_push_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            data_push_valid = 1'b1; data_push_data = 32'h50 + 32'(k);
            tick();
            data_push_valid = 1'b0;
            chk("il_valid", 64'(data_pop_valid), 64'(1));
            chk("il_data",  64'(data_pop_data), 64'(32'h50 + 32'(k)));
            chk("il_addr",  64'(data_pop_addr), 64'((k == 2) ? 32'h4000 : 32'h3000 + 32'(4 * k)));
            chk("il_last",  64'(data_pop_last), 64'(k != 0));
            chk("il_id",    64'(info_id), 64'((k == 2) ? 2 : 1));
            tick();
            tick();
        end
        chk("il_retired", 64'(info_valid), 64'(0));
        chk("il_unf0",    64'(underflow_err), 64'(0));
        data_push_valid = 1'b1; data_push_data = 32'h99;
        tick();
        data_push_valid = 1'b0;
        chk("il_unf1",     64'(underflow_err), 64'(1));
        chk("il_stored",   64'(data_count), 64'(1));
        chk("il_no_pop",   64'(data_pop_valid), 64'(0));
        data_pop_ready = 1'b0;

        // Flush clears leftovers and sticky errors
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_count", 64'(data_count), 64'(0));
        chk("fl_unf",   64'(underflow_err), 64'(0));
        chk("fl_ovf",   64'(overflow_err), 64'(0));
        chk("fl_data",  64'(data_pop_data), 64'(0));
        chk("fl_ready", 64'(data_push_ready), 64'(1));

        // Flush mid-burst after 2 of 4 beats popped
        info_push_valid = 1'b1; info_push_addr = 32'h5000; info_push_len = 8'd3; info_push_id = 4'd9;
        tick();
        info_push_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            data_push_valid = 1'b1; data_push_data = 32'hE0 + 32'(i);
            tick();
        end
        data_push_valid = 1'b0;
        data_pop_ready = 1'b1;
        tick(); tick();
        chk("mf_head_data", 64'(data_pop_data), 64'(32'hE2));
        chk("mf_head_addr", 64'(data_pop_addr), 64'(32'h5008));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("mf_info_valid", 64'(info_valid), 64'(0));
        chk("mf_pop_valid",  64'(data_pop_valid), 64'(0));
        chk("mf_count",      64'(data_count), 64'(0));
        chk("mf_last",       64'(data_pop_last), 64'(0));
        chk("mf_addr",       64'(data_pop_addr), 64'(0));
        chk("mf_data",       64'(data_pop_data), 64'(0));
        chk("mf_info_ready", 64'(info_push_ready), 64'(1));
        data_pop_ready = 1'b0;

        // New burst after flush
        info_push_valid = 1'b1; info_push_addr = 32'h6000; info_push_len = 8'd1; info_push_id = 4'd4;
        tick();
        info_push_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            data_push_valid = 1'b1; data_push_data = 32'hF0 + 32'(i);
            tick();
        end
        data_push_valid = 1'b0;
        data_pop_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk("nb_addr", 64'(data_pop_addr), 64'(32'h6000 + 32'(4 * i)));
            chk("nb_data", 64'(data_pop_data), 64'(32'hF0 + 32'(i)));
            chk("nb_last", 64'(data_pop_last), 64'(i == 1));
            tick();
        end
        data_pop_ready = 1'b0;
        chk("nb_retired", 64'(info_valid), 64'(0));
        chk("nb_unf",     64'(underflow_err), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
